// File: rtl/fpu_issue_ctrl.sv
// In-order issue controller for the half-precision FPU. It decodes the instruction,
// tracks RAW/WAW hazards in a scoreboard, and reserves the shared writeback slot at issue.
module fpu_issue_ctrl #(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 12,
  parameter int MISC_LAT = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        flush,
  input  logic [2:0]  frm,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        add_start,
  output logic        mul_start,
  output logic        div_start,
  output logic        misc_start,
  output logic [4:0]  op_funct5,
  output logic [2:0]  op_rm,
  output logic [4:0]  op_rs1,
  output logic [4:0]  op_rs2,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_unit,
  output logic        wb_int,
  output logic        ill_instr,
  output logic        busy
);

  localparam int         CW      = $clog2(DIV_LAT);
  localparam logic [6:0] OPC_FP  = 7'b1010011;
  localparam logic [1:0] FMT_H   = 2'b10;
  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SUB  = 5'b00001;
  localparam logic [4:0] F5_MUL  = 5'b00010;
  localparam logic [4:0] F5_DIV  = 5'b00011;
  localparam logic [4:0] F5_SQRT = 5'b01011;
  localparam logic [4:0] F5_SGNJ = 5'b00100;
  localparam logic [4:0] F5_MNMX = 5'b00101;
  localparam logic [4:0] F5_COMP = 5'b10100;
  localparam logic [4:0] F5_CLAS = 5'b11100;
  localparam logic [1:0] U_ADD   = 2'd0;
  localparam logic [1:0] U_MUL   = 2'd1;
  localparam logic [1:0] U_DIV   = 2'd2;
  localparam logic [1:0] U_MISC  = 2'd3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [1:0] unit;
    logic       is_int;
  } slot_t;

  slot_t         slot_q [DIV_LAT];
  slot_t         slot_d [DIV_LAT];
  logic [31:0]   sb_q, sb_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          rst_done_q;

  logic [6:0] opcode_s;
  logic [4:0] rd_s, rs1_s, rs2_s, funct5_s;
  logic [2:0] rm_s, rm_res_s, op_rm_s;
  logic [1:0] fmt_s, unit_s;
  logic       known_s, arith_s, uses_rs2_s, fp_dst_s;
  logic       legal_s, hazard_s, slot_free_s, div_ok_s, can_issue_s;
  logic       active_s, issue_s, any_slot_s;
  slot_t      new_slot_s;

  assign opcode_s = in_instr[6:0];
  assign rd_s     = in_instr[11:7];
  assign rm_s     = in_instr[14:12];
  assign rs1_s    = in_instr[19:15];
  assign rs2_s    = in_instr[24:20];
  assign fmt_s    = in_instr[26:25];
  assign funct5_s = in_instr[31:27];

  always_comb begin
    known_s    = 1'b1;
    arith_s    = 1'b0;
    uses_rs2_s = 1'b1;
    fp_dst_s   = 1'b1;
    unit_s     = U_ADD;
    case (funct5_s)
      F5_ADD, F5_SUB:   begin arith_s = 1'b1; unit_s = U_ADD; end
      F5_MUL:           begin arith_s = 1'b1; unit_s = U_MUL; end
      F5_DIV:           begin arith_s = 1'b1; unit_s = U_DIV; end
      F5_SQRT:          begin arith_s = 1'b1; unit_s = U_DIV; uses_rs2_s = 1'b0; end
      F5_SGNJ, F5_MNMX: begin unit_s = U_MISC; end
      F5_COMP:          begin unit_s = U_MISC; fp_dst_s = 1'b0; end
      F5_CLAS:          begin unit_s = U_MISC; fp_dst_s = 1'b0; uses_rs2_s = 1'b0; end
      default:          begin known_s = 1'b0; end
    endcase
  end

  // Dynamic rounding resolves through frm; MISC ops carry rm as a raw sub-op select.
  assign rm_res_s = (rm_s == 3'b111) ? frm : rm_s;
  assign op_rm_s  = arith_s ? rm_res_s : rm_s;
  assign legal_s  = (opcode_s == OPC_FP) && (fmt_s == FMT_H) && known_s &&
                    (uses_rs2_s || (rs2_s == 5'd0)) &&
                    (!arith_s || (rm_res_s <= 3'd4));

  assign hazard_s = sb_q[rs1_s] | (uses_rs2_s & sb_q[rs2_s]) | (fp_dst_s & sb_q[rd_s]);
  assign div_ok_s = (unit_s != U_DIV) || (div_cnt_q == '0);

  always_comb begin
    case (unit_s)
      U_ADD:   slot_free_s = ~slot_q[ADD_LAT].v;
      U_MUL:   slot_free_s = ~slot_q[MUL_LAT].v;
      U_MISC:  slot_free_s = ~slot_q[MISC_LAT].v;
      default: slot_free_s = 1'b1;  // DIV lands beyond every existing reservation
    endcase
  end

  assign can_issue_s = legal_s & ~hazard_s & slot_free_s & div_ok_s;
  assign active_s    = rst_done_q & ~flush;
  assign issue_s     = in_valid & active_s & can_issue_s;
  assign new_slot_s  = {1'b1, rd_s, unit_s, ~fp_dst_s};

  always_comb begin
    for (int i = 0; i < DIV_LAT - 1; i++) begin
      slot_d[i] = slot_q[i + 1];
    end
    slot_d[DIV_LAT - 1] = '0;
    sb_d = sb_q;
    if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - CW'(1);
    end else begin
      div_cnt_d = div_cnt_q;
    end
    if (slot_q[0].v && !slot_q[0].is_int) begin
      sb_d[slot_q[0].rd] = 1'b0;
    end else begin
      sb_d = sb_d;
    end
    if (issue_s) begin
      case (unit_s)
        U_ADD:   slot_d[ADD_LAT - 1]  = new_slot_s;
        U_MUL:   slot_d[MUL_LAT - 1]  = new_slot_s;
        U_DIV:   slot_d[DIV_LAT - 1]  = new_slot_s;
        default: slot_d[MISC_LAT - 1] = new_slot_s;
      endcase
      if (fp_dst_s) begin
        sb_d[rd_s] = 1'b1;
      end else begin
        sb_d = sb_d;
      end
      if (unit_s == U_DIV) begin
        div_cnt_d = CW'(DIV_LAT - 1);
      end else begin
        div_cnt_d = div_cnt_d;
      end
    end else begin
      sb_d = sb_d;
    end
    if (flush) begin
      for (int i = 0; i < DIV_LAT; i++) begin
        slot_d[i] = '0;
      end
      sb_d      = '0;
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rst_done_q <= 1'b0;
      sb_q       <= '0;
      div_cnt_q  <= '0;
      for (int i = 0; i < DIV_LAT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      rst_done_q <= 1'b1;
      sb_q       <= sb_d;
      div_cnt_q  <= div_cnt_d;
      slot_q     <= slot_d;
    end
  end

  always_comb begin
    any_slot_s = 1'b0;
    for (int i = 0; i < DIV_LAT; i++) begin
      any_slot_s = any_slot_s | slot_q[i].v;
    end
  end

  assign in_ready   = active_s & (~legal_s | can_issue_s);
  assign ill_instr  = in_valid & active_s & ~legal_s;
  assign add_start  = issue_s & (unit_s == U_ADD);
  assign mul_start  = issue_s & (unit_s == U_MUL);
  assign div_start  = issue_s & (unit_s == U_DIV);
  assign misc_start = issue_s & (unit_s == U_MISC);
  assign op_funct5  = issue_s ? funct5_s : 5'd0;
  assign op_rm      = issue_s ? op_rm_s  : 3'd0;
  assign op_rs1     = issue_s ? rs1_s    : 5'd0;
  assign op_rs2     = issue_s ? rs2_s    : 5'd0;
  assign wb_valid   = slot_q[0].v & ~flush;
  assign wb_rd      = wb_valid ? slot_q[0].rd     : 5'd0;
  assign wb_unit    = wb_valid ? slot_q[0].unit   : 2'd0;
  assign wb_int     = wb_valid ? slot_q[0].is_int : 1'b0;
  assign busy       = any_slot_s | (|sb_q) | (div_cnt_q != '0);

endmodule
